// File: rtl/bus_arbiter16.sv
// Round-robin arbiter granting one 8-bit system bus to one of 16 requesters, with a one-cycle turnaround gap.
// Define ARB_TIMEOUT_EN to enable the HOLD_MAX hold-time watchdog and the timeout pulse.
module bus_arbiter16 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        rel,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  owner_q, owner_d;
  logic        pick_found_s;
  logic [3:0]  pick_idx_s;
  logic [3:0]  cand_s;
  logic        end_norm_s;
  logic        wd_hit_s;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = HOLD_MAX[7:0];
  logic [7:0]  hold_q, hold_d;
  logic        wd_q, wd_d;
`endif

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  // Round-robin search: first set request at or after ptr, wrapping 15 -> 0.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = ptr_q;
    cand_s       = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand_s = ptr_q + i[3:0];
      if (!pick_found_s && req[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Tenure end conditions; a normal release wins over a coincident watchdog expiry.
  always_comb begin
    end_norm_s = rel | ~req[owner_q];
`ifdef ARB_TIMEOUT_EN
    wd_hit_s   = (hold_q == HOLD_LIM);
`else
    wd_hit_s   = 1'b0;
`endif
  end

  // Next-state logic for the IDLE/BUSY/GAP controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    wd_d    = wd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_BUSY;
          owner_d = pick_idx_s;
          ptr_d   = pick_idx_s + 4'd1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd1;
          wd_d    = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (end_norm_s || wd_hit_s) begin
          state_d = ST_GAP;
`ifdef ARB_TIMEOUT_EN
          wd_d    = ~end_norm_s;
`endif
        end else begin
          state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_d  = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
        hold_d  = 8'd0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 4'd0;
      owner_q <= 4'd0;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
      wd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      wd_q    <= wd_d;
`endif
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  always_comb begin
    if (state_q == ST_BUSY) begin
      gnt       = onehot16(owner_q);
      gnt_idx   = owner_q;
      gnt_valid = 1'b1;
    end else begin
      gnt       = 16'h0000;
      gnt_idx   = 4'd0;
      gnt_valid = 1'b0;
    end
`ifdef ARB_TIMEOUT_EN
    timeout = (state_q == ST_GAP) & wd_q;
`else
    timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_arbiter16.sv
// Directed bench for bus_arbiter16: vector table plus hand-written multi-cycle sequences.
module tb_bus_arbiter16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        rel;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        to;
  } vec_t;

  vec_t vecs[16];

  bus_arbiter16 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [15:0] eg, input logic [3:0] ei,
                         input logic ev, input logic et);
    chk({name, ".gnt"},       {16'h0, gnt},      {16'h0, eg});
    chk({name, ".gnt_idx"},   {28'h0, gnt_idx},  {28'h0, ei});
    chk({name, ".gnt_valid"}, {31'h0, gnt_valid}, {31'h0, ev});
    chk({name, ".timeout"},   {31'h0, timeout},  {31'h0, et});
  endtask

  // Drive inputs at the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [15:0] r, input logic rl);
    @(negedge clk);
    req = r;
    rel = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 16'h0000;
    rel   = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    req   = 16'h0000;
    rel   = 1'b0;

    vecs[0]  = '{16'h0001, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{16'h0001, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
    vecs[2]  = '{16'h0001, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
    vecs[3]  = '{16'h0001, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{16'h0011, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0};
    vecs[6]  = '{16'h0011, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{16'h0011, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{16'h0011, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
    vecs[9]  = '{16'h0010, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{16'h0010, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{16'h0010, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0};
    vecs[12] = '{16'h0013, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0};
    vecs[13] = '{16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[14] = '{16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[15] = '{16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};

    #12;
    chk_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].req, vecs[i].rel);
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].to);
    end

    // Full contention: strict rotation 0..15 then wrap to 0, two empty bus cycles between owners.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(16'hFFFF, 1'b0);
      chk_out($sformatf("rr%0d.grant", k), 16'h0001 << (k % 16), 4'(k % 16), 1'b1, 1'b0);
      step(16'hFFFF, 1'b1);
      chk_out($sformatf("rr%0d.gap", k), 16'h0000, 4'd0, 1'b0, 1'b0);
      step(16'hFFFF, 1'b0);
      chk_out($sformatf("rr%0d.idle", k), 16'h0000, 4'd0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a grant to requester 15.
    do_reset();
    step(16'h8000, 1'b0);
    chk_out("rst.grant15", 16'h8000, 4'd15, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h8000, 1'b0);
    chk_out("rst.regrant15", 16'h8000, 4'd15, 1'b1, 1'b0);

    // Owner never releases: watchdog reclaims after HOLD_MAX=4 cycles when enabled.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step(16'h0100, 1'b0);
      chk_out($sformatf("wd.hold%0d", c), 16'h0100, 4'd8, 1'b1, 1'b0);
    end
    step(16'h0100, 1'b0);
`ifdef ARB_TIMEOUT_EN
    chk_out("wd.gap", 16'h0000, 4'd0, 1'b0, 1'b1);
    step(16'h0100, 1'b0);
    chk_out("wd.idle", 16'h0000, 4'd0, 1'b0, 1'b0);
`else
    chk_out("wd.hold5", 16'h0100, 4'd8, 1'b1, 1'b0);
    step(16'h0100, 1'b0);
    chk_out("wd.hold6", 16'h0100, 4'd8, 1'b1, 1'b0);
`endif
    step(16'h0100, 1'b0);
    chk_out("wd.regrant", 16'h0100, 4'd8, 1'b1, 1'b0);

    // Release coincident with the final allowed cycle is a normal release.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step(16'h0100, 1'b0);
      chk_out($sformatf("relmax.hold%0d", c), 16'h0100, 4'd8, 1'b1, 1'b0);
    end
    step(16'h0100, 1'b1);
    chk_out("relmax.gap", 16'h0000, 4'd0, 1'b0, 1'b0);
    step(16'h0000, 1'b0);
    chk_out("relmax.idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter16.md
# bus_arbiter16

Round-robin arbiter that shares the single 8-bit system bus among up to 16 requesters and drives the bus-select one-hot lines. It sits between requesting units (CPU core, DMA, peripherals) and the bus-select decode, so exactly one unit owns the bus at a time. It uses a request/grant/release handshake, a one-cycle turnaround gap between owners, and an optional hold-time watchdog that forcibly reclaims the bus.

## Interface
Parameters:
- HOLD_MAX, 15: maximum consecutive cycles one owner may hold the grant; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  16  request lines; bit i = requester i wants the bus; level-sensitive, held until granted and finished.
- rel  in  1  release strobe from the current owner; sampled only in BUSY.
- gnt  out  16  one-hot grant; bit i high = requester i owns the bus; all-zero when no owner.
- gnt_idx  out  4  binary index of current owner; 0 when gnt_valid low.
- gnt_valid  out  1  high while any gnt bit is high.
- timeout  out  1  one-cycle pulse when a grant is forcibly reclaimed.

## Operation
- States: IDLE, BUSY, GAP. Reset state IDLE.
- Registers: ptr[3:0] (round-robin start), owner[3:0], hold_cnt[7:0].
- IDLE: if req != 0, pick the first set bit searching ascending from ptr with wrap 15->0; owner <= that index, ptr <= index+1 mod 16, hold_cnt <= 1, go BUSY. If req == 0, stay IDLE.
- BUSY: gnt = one-hot(owner), gnt_idx = owner, gnt_valid = 1. End of tenure when any of: rel = 1; req[owner] = 0; hold_cnt == HOLD_MAX (watchdog). On end, go GAP. Otherwise hold_cnt <= hold_cnt + 1 (saturating at 255).
- Simultaneous: rel or req drop in the same cycle that hold_cnt == HOLD_MAX counts as a normal release; no timeout.
- GAP: one cycle, all grant outputs low (bus turnaround); timeout = 1 in this cycle only if tenure ended by watchdog. Always go IDLE.
- Requests other than the owner's are ignored while BUSY; no preemption.
- A requester that keeps req high after release re-enters arbitration normally; round robin guarantees every other pending requester is served first.
- gnt, gnt_idx, gnt_valid are decoded from registered state only (no combinational path from req/rel to outputs).

## Timing
- Reset (async assert): state IDLE, ptr 0, owner 0, hold_cnt 0; gnt 0, gnt_idx 0, gnt_valid 0, timeout 0 immediately, regardless of state. Reset mid-grant drops the grant in the same cycle.
- Grant latency: req sampled high in IDLE at edge N -> gnt valid after edge N (one cycle).
- Release latency: rel sampled at edge M -> gnt low after M (GAP), IDLE after M+1, next grant after M+2. Minimum owner-to-owner spacing: 2 idle-bus cycles.
- Watchdog: owner holds gnt exactly HOLD_MAX cycles; timeout high for the single GAP cycle that follows.
- Minimum tenure: 1 cycle (rel high in first BUSY cycle).

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined: hold_cnt and watchdog as above; timeout output active.
- Undefined: no hold counter; tenure ends only on rel or req[owner] drop; timeout tied 0; HOLD_MAX ignored.

## Test plan
- Reset then req=16'h0001, rel pulsed after 3 BUSY cycles -> gnt=16'h0001, gnt_idx=0 one cycle after req; gnt low for GAP; ptr=1.
- req=16'hFFFF held, rel pulsed each tenure -> grant order 0,1,2,...,15,0 with gnt_idx wrapping 15->0, two grant-free cycles between owners.
- ptr=5 (after granting 4), req=16'h0011 -> requester 4 skipped, 0 granted after wrap? No: first set bit from 5 ascending with wrap is 0 -> gnt=16'h0001.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=16'h0100, rel never -> gnt=16'h0100 for exactly 4 cycles, timeout=1 for one cycle, regrant of 8 after GAP+IDLE.
- HOLD_MAX=4, rel asserted in 4th BUSY cycle -> grant ends, timeout stays 0.
- rst_n low mid-BUSY with gnt=16'h8000 -> all outputs 0 asynchronously; after release, req=16'h8000 granted with ptr search from 0.
